// File: rtl/if_mem_arbiter_if.sv
// Bundle of pipeline-side and RAM-side signals around the unified memory arbiter.
// The master modport is the arbiter; the slave modport is the pipeline plus RAM controller.
interface if_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] if_addr;
  logic              branch_taken;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  logic [DATA_W-1:0] inst;
  logic              inst_valid;
  logic              freeze;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ack;
  logic              timeout_err;

  modport master (
    input  if_addr, branch_taken, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
           ram_rdata, ram_ack,
    output mem_rdata, mem_done, inst, inst_valid, freeze,
           ram_req, ram_we, ram_addr, ram_wdata, timeout_err
  );

  modport slave (
    output if_addr, branch_taken, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
           ram_rdata, ram_ack,
    input  mem_rdata, mem_done, inst, inst_valid, freeze,
           ram_req, ram_we, ram_addr, ram_wdata, timeout_err
  );
endinterface

// File: rtl/if_mem_arbiter.sv
// Shares one multi-cycle RAM port between instruction fetch and MEM-stage data access; freezes the pipeline until a fetch completes.
// Optional ram_ack watchdog enabled by IF_MEM_ARB_TIMEOUT_EN.
module if_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  if_mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              inst_valid_q, inst_valid_d;
  logic              data_done_q, data_done_d;
  logic              mem_done_q, mem_done_d;
  logic              timeout_err_q, timeout_err_d;

  logic              pending;
  logic              freeze;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;

`ifdef IF_MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] wait_inc;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  always_comb begin
    state_d       = state_q;
    inst_d        = inst_q;
    inst_valid_d  = inst_valid_q;
    mem_rdata_d   = mem_rdata_q;
    mem_done_d    = 1'b0;
    timeout_err_d = timeout_err_q;
    ram_req       = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = bus.if_addr;

    // A served access must not replay while the request stays asserted under freeze.
    pending     = (bus.mem_rd_en | bus.mem_wr_en) & ~data_done_q;
    freeze      = ~((state_q == FETCH) & bus.ram_ack & ~pending);
    data_done_d = freeze ? data_done_q : 1'b0;

    case (state_q)
      IDLE: begin
        state_d = pending ? DATA : FETCH;
      end
      FETCH: begin
        ram_req = 1'b1;
        if (bus.ram_ack) begin
          state_d      = IDLE;
          inst_d       = bus.ram_rdata;
          inst_valid_d = ~bus.branch_taken;
        end
      end
      DATA: begin
        ram_req  = 1'b1;
        ram_we   = bus.mem_wr_en;
        ram_addr = bus.mem_addr;
        if (bus.ram_ack) begin
          state_d     = IDLE;
          mem_done_d  = 1'b1;
          data_done_d = 1'b1;
          if (!bus.mem_wr_en) mem_rdata_d = bus.ram_rdata;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef IF_MEM_ARB_TIMEOUT_EN
    wait_inc = wait_q + 1'b1;
    wait_d   = (state_q == IDLE) ? '0 : wait_q;
    if (ram_req && !bus.ram_ack) begin
      wait_d = wait_inc;
      if (wait_inc == CNT_W'(TIMEOUT)) begin
        state_d       = IDLE;
        timeout_err_d = 1'b1;
        if (state_q == FETCH) inst_valid_d = 1'b0;
        else                  data_done_d  = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      inst_q        <= '0;
      inst_valid_q  <= 1'b0;
      mem_rdata_q   <= '0;
      data_done_q   <= 1'b0;
      mem_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      inst_q        <= inst_d;
      inst_valid_q  <= inst_valid_d;
      mem_rdata_q   <= mem_rdata_d;
      data_done_q   <= data_done_d;
      mem_done_q    <= mem_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

`ifdef IF_MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wait_q <= '0;
    else      wait_q <= wait_d;
  end
  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.inst       = inst_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.mem_rdata  = mem_rdata_q;
  assign bus.mem_done   = mem_done_q;
  assign bus.freeze     = freeze;
  assign bus.ram_req    = ram_req;
  assign bus.ram_we     = ram_we;
  assign bus.ram_addr   = ram_addr;
  assign bus.ram_wdata  = bus.mem_wdata;

endmodule

// File: tb/tb_if_mem_arbiter.sv
// Bench: pipeline driver plus latency-programmable RAM responder; each instruction checked against
// expected stall length, RAM transactions, and fetched/loaded values from a word-level memory model.
module tb_if_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  if_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        log_q[$];
  logic [31:0] ram_arr [logic [31:0]];
  logic [31:0] exp_mem [logic [31:0]];
  int          checks = 0;
  int          errors = 0;
  int          lat = 0;
  logic [31:0] pc = 32'h0;
  logic [31:0] exp_rdata = 32'h0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] ram_val(input logic [31:0] a);
    return ram_arr.exists(a) ? ram_arr[a] : init_val(a);
  endfunction

  function automatic logic [31:0] model_val(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : init_val(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RAM controller: acks after `lat` extra wait cycles, logs every completed transaction.
  initial begin
    int          cnt;
    logic [31:0] a0;
    cnt = 0;
    a0  = '0;
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.ram_ack = 1'b0;
      if (bus.ram_req === 1'b1) begin
        if (cnt == 0) a0 = bus.ram_addr;
        else check("ram_addr_stable", bus.ram_addr, a0);
        if (cnt >= lat) begin
          bus.ram_ack   = 1'b1;
          bus.ram_rdata = ram_val(bus.ram_addr);
          if (bus.ram_we === 1'b1) ram_arr[bus.ram_addr] = bus.ram_wdata;
          log_q.push_back('{we: bus.ram_we, addr: bus.ram_addr, wdata: bus.ram_wdata});
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // One pipeline step: drive the request set, wait for freeze to drop, then check the outcome.
  task automatic run_instr(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic br, input int latency);
    int          cycles, dones, expc, ntx;
    logic [31:0] expi;
    logic        is_data, is_store;
    is_data  = rd | wr;
    is_store = wr;
    lat      = latency;
    bus.if_addr      = pc;
    bus.mem_rd_en    = rd;
    bus.mem_wr_en    = wr;
    bus.mem_addr     = addr;
    bus.mem_wdata    = wdata;
    bus.branch_taken = br;
    log_q.delete();
    if (is_store)     exp_mem[addr] = wdata;
    else if (is_data) exp_rdata = model_val(addr);
    expi = model_val(pc);
    expc = is_data ? 2 * latency + 4 : latency + 2;
    ntx  = is_data ? 2 : 1;
    cycles = 0;
    dones  = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (bus.mem_done === 1'b1) dones++;
    end while (bus.freeze !== 1'b0 && cycles < 60);
    check("cycles_per_advance", 32'(cycles), 32'(expc));
    check("mem_done_pulses", 32'(dones), 32'(is_data));
    check("ram_txn_count", 32'(log_q.size()), 32'(ntx));
    if (log_q.size() == ntx) begin
      if (is_data) begin
        check("data_we", 32'(log_q[0].we), 32'(is_store));
        check("data_addr", log_q[0].addr, addr);
        if (is_store) check("data_wdata", log_q[0].wdata, wdata);
      end
      check("fetch_we", 32'(log_q[ntx-1].we), 32'h0);
      check("fetch_addr", log_q[ntx-1].addr, pc);
    end
    @(posedge clk);
    #1;
    check("inst", bus.inst, expi);
    check("inst_valid", 32'(bus.inst_valid), 32'(!br));
    check("mem_rdata", bus.mem_rdata, exp_rdata);
    check("mem_done_after", 32'(bus.mem_done), 32'h0);
    pc = br ? 32'(4 * $urandom_range(0, 63)) : pc + 32'd4;
  endtask

  initial begin
    bus.if_addr      = '0;
    bus.branch_taken = 1'b0;
    bus.mem_rd_en    = 1'b0;
    bus.mem_wr_en    = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    ram_arr[32'h100] = 32'hDEADBEEF;
    exp_mem[32'h100] = 32'hDEADBEEF;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_freeze", 32'(bus.freeze), 32'h1);
    check("rst_inst", bus.inst, 32'h0);
    check("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
    check("rst_mem_rdata", bus.mem_rdata, 32'h0);
    check("rst_mem_done", 32'(bus.mem_done), 32'h0);
    check("rst_ram_req", 32'(bus.ram_req), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Zero-wait fetches at 0, 4, 8
    run_instr(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0);
    run_instr(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0);
    run_instr(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0);
    // Slow RAM fetch at 0x10
    pc = 32'h10;
    run_instr(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 3);
    // Load, store, readback, combined rd+wr treated as store
    run_instr(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1);
    run_instr(1'b0, 1'b1, 32'h200, 32'h12345678, 1'b0, 2);
    run_instr(1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 0);
    run_instr(1'b1, 1'b1, 32'h204, 32'hCAFEF00D, 1'b0, 1);
    run_instr(1'b1, 1'b0, 32'h204, 32'h0, 1'b0, 2);
    // Branch squash, then fetch from the new target
    run_instr(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 0);
    run_instr(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 2);
    run_instr(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      run_instr(op[0], op[1], 32'h100 + 32'(4 * $urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end

    bus.mem_rd_en    = 1'b0;
    bus.mem_wr_en    = 1'b0;
    bus.branch_taken = 1'b0;
`ifdef IF_MEM_ARB_TIMEOUT_EN
    begin
      int reqc;
      reqc = 0;
      lat  = 1000;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (bus.ram_req === 1'b1) reqc++;
        else if (reqc > 0) break;
      end
      check("timeout_wait_cycles", 32'(reqc), 32'd8);
      check("timeout_ram_req", 32'(bus.ram_req), 32'h0);
      check("timeout_err", 32'(bus.timeout_err), 32'h1);
      check("timeout_inst_valid", 32'(bus.inst_valid), 32'h0);
    end
`else
    @(negedge clk);
    check("timeout_err_tied", 32'(bus.timeout_err), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
